// File: rtl/bist_signature_analyzer_if.sv
// Handshake/bus bundle between the BIST controller (master) and the
// signature analyzer (slave). Optional golden_signature input is present
// only when MISR_GOLDEN_PORT_EN is defined.
interface bist_signature_analyzer_if #(
    parameter int WIDTH = 4
);
    logic             BIST_mode;
    logic             start;
    logic             din_valid;
    logic [WIDTH-1:0] result_dut;
    logic [WIDTH-1:0] misr_output;
    logic             busy;
    logic             finish;
    logic             fault_detected;
`ifdef MISR_GOLDEN_PORT_EN
    logic [WIDTH-1:0] golden_signature;

    modport master (
        output BIST_mode, start, din_valid, result_dut, golden_signature,
        input  misr_output, busy, finish, fault_detected
    );

    modport slave (
        input  BIST_mode, start, din_valid, result_dut, golden_signature,
        output misr_output, busy, finish, fault_detected
    );
`else
    modport master (
        output BIST_mode, start, din_valid, result_dut,
        input  misr_output, busy, finish, fault_detected
    );

    modport slave (
        input  BIST_mode, start, din_valid, result_dut,
        output misr_output, busy, finish, fault_detected
    );
`endif
endinterface

// File: rtl/bist_signature_analyzer.sv
// Output-response compactor: folds CUT results into a MISR for a fixed
// number of valid samples, then compares the signature against a golden
// value. Optional feature macro: MISR_GOLDEN_PORT_EN (golden value taken
// from a port and captured at run start instead of the GOLDEN parameter).
module bist_signature_analyzer #(
    parameter int               WIDTH         = 4,
    parameter int               PATTERN_COUNT = 16,
    parameter logic [WIDTH-1:0] POLY          = 4'b0011,
    parameter logic [WIDTH-1:0] SEED          = 4'b0000,
    parameter logic [WIDTH-1:0] GOLDEN        = 4'b0101
) (
    input  logic                        clk,
    input  logic                        rst,
    bist_signature_analyzer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

    localparam logic [15:0] LAST_IDX = 16'(PATTERN_COUNT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [15:0]      count_q, count_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] misr_step;
    logic [WIDTH-1:0] golden_ref;
    logic             run_req;

`ifdef MISR_GOLDEN_PORT_EN
    logic [WIDTH-1:0] golden_q, golden_d;
    assign golden_ref = golden_q;
`else
    assign golden_ref = GOLDEN;
`endif

    assign run_req = bus.start && bus.BIST_mode;

    // One MISR shift: Galois feedback from the MSB, then fold in the CUT result.
    assign misr_step = {misr_q[WIDTH-2:0], 1'b0}
                     ^ (misr_q[WIDTH-1] ? POLY : '0)
                     ^ bus.result_dut;

    // Next-state and next-output logic for the run/compare sequence.
    always_comb begin
        // NOTE: every _d starts as a hold value so no path leaves a latch.
        state_d = state_q;
        misr_d  = misr_q;
        count_d = count_q;
        fault_d = fault_q;
`ifdef MISR_GOLDEN_PORT_EN
        golden_d = golden_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (run_req) begin
                    state_d = RUN;
                    misr_d  = SEED;
                    count_d = '0;
                    fault_d = 1'b0;
`ifdef MISR_GOLDEN_PORT_EN
                    golden_d = bus.golden_signature;
`endif
                end
            end
            RUN: begin
                if (!bus.BIST_mode) begin
                    state_d = IDLE;
                    misr_d  = SEED;
                    count_d = '0;
                end else if (bus.din_valid) begin
                    misr_d  = misr_step;
                    count_d = count_q + 16'd1;
                    if (count_q == LAST_IDX) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                if (!bus.BIST_mode) begin
                    state_d = IDLE;
                    misr_d  = SEED;
                    count_d = '0;
                end else begin
                    fault_d = (misr_q != golden_ref);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (run_req) begin
                    state_d = RUN;
                    misr_d  = SEED;
                    count_d = '0;
                    fault_d = 1'b0;
`ifdef MISR_GOLDEN_PORT_EN
                    golden_d = bus.golden_signature;
`endif
                end else if (!bus.BIST_mode) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags follow the next state so they leave the flops aligned with it.
        busy_d   = (state_d == RUN) || (state_d == COMPARE);
        finish_d = (state_d == DONE);
    end

    // State and output registers; async reset returns everything to idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            misr_q   <= SEED;
            count_q  <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            fault_q  <= 1'b0;
`ifdef MISR_GOLDEN_PORT_EN
            golden_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            misr_q   <= misr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            fault_q  <= fault_d;
`ifdef MISR_GOLDEN_PORT_EN
            golden_q <= golden_d;
`endif
        end
    end

    assign bus.misr_output    = misr_q;
    assign bus.busy           = busy_q;
    assign bus.finish         = finish_q;
    assign bus.fault_detected = fault_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Bench for bist_signature_analyzer: two instances (golden 1110 and 0101)
// see identical stimulus; a sample-level model predicts every output each
// cycle, and directed checks pin hand-computed values.
module tb_bist_signature_analyzer;

    localparam int         PC     = 4;
    localparam logic [3:0] GOLD_A = 4'b1110;
    localparam logic [3:0] GOLD_B = 4'b0101;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bist_signature_analyzer_if #(.WIDTH(4)) if_a ();
    bist_signature_analyzer_if #(.WIDTH(4)) if_b ();

    assign if_b.BIST_mode  = if_a.BIST_mode;
    assign if_b.start      = if_a.start;
    assign if_b.din_valid  = if_a.din_valid;
    assign if_b.result_dut = if_a.result_dut;

    bist_signature_analyzer #(
        .WIDTH(4), .PATTERN_COUNT(PC), .POLY(4'b0011), .SEED(4'b0000), .GOLDEN(GOLD_A)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );

    bist_signature_analyzer #(
        .WIDTH(4), .PATTERN_COUNT(PC), .POLY(4'b0011), .SEED(4'b0000), .GOLDEN(GOLD_B)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Multiply the signature by x modulo x^4+x+1, then add the new response.
    function automatic logic [3:0] clock_in(input logic [3:0] m, input logic [3:0] d);
        int v;
        v = int'(m) * 2;
        if (v >= 16) v = (v - 16) ^ 3;
        return 4'(v) ^ d;
    endfunction

    // Model: phase 0 idle, 1 collecting, 2 comparing, 3 done.
    int         phase;
    int         n_seen;
    logic [3:0] sig;
    logic       exp_fa, exp_fb;
    logic [3:0] ref_a, ref_b;

    task automatic model_reload();
        phase  = 1;
        sig    = 4'b0000;
        n_seen = 0;
        exp_fa = 1'b0;
        exp_fb = 1'b0;
`ifdef MISR_GOLDEN_PORT_EN
        ref_a = if_a.golden_signature;
        ref_b = if_b.golden_signature;
`else
        ref_a = GOLD_A;
        ref_b = GOLD_B;
`endif
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  = 0;
            sig    = 4'b0000;
            n_seen = 0;
            exp_fa = 1'b0;
            exp_fb = 1'b0;
        end else begin
            case (phase)
                0: if (if_a.start && if_a.BIST_mode) model_reload();
                1: begin
                    if (!if_a.BIST_mode) begin
                        phase  = 0;
                        sig    = 4'b0000;
                        n_seen = 0;
                    end else if (if_a.din_valid) begin
                        sig = clock_in(sig, if_a.result_dut);
                        n_seen++;
                        if (n_seen == PC) phase = 2;
                    end
                end
                2: begin
                    if (!if_a.BIST_mode) begin
                        phase  = 0;
                        sig    = 4'b0000;
                        n_seen = 0;
                    end else begin
                        exp_fa = (sig != ref_a);
                        exp_fb = (sig != ref_b);
                        phase  = 3;
                    end
                end
                default: begin
                    if (if_a.start && if_a.BIST_mode) model_reload();
                    else if (!if_a.BIST_mode) begin
                        phase  = 0;
                        exp_fa = 1'b0;
                        exp_fb = 1'b0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("a_misr",   if_a.misr_output, sig);
        check("b_misr",   if_b.misr_output, sig);
        check("a_busy",   {3'b0, if_a.busy},   {3'b0, (phase == 1 || phase == 2)});
        check("b_busy",   {3'b0, if_b.busy},   {3'b0, (phase == 1 || phase == 2)});
        check("a_finish", {3'b0, if_a.finish}, {3'b0, (phase == 3)});
        check("b_finish", {3'b0, if_b.finish}, {3'b0, (phase == 3)});
        check("a_fault",  {3'b0, if_a.fault_detected}, {3'b0, exp_fa});
        check("b_fault",  {3'b0, if_b.fault_detected}, {3'b0, exp_fb});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        if_a.BIST_mode = 1'b1;
        if_a.start     = 1'b1;
        tick();
        if_a.start     = 1'b0;
    endtask

    task automatic sample(input logic [3:0] d);
        if_a.din_valid  = 1'b1;
        if_a.result_dut = d;
        tick();
        if_a.din_valid  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        if_a.BIST_mode  = 1'b0;
        if_a.start      = 1'b0;
        if_a.din_valid  = 1'b0;
        if_a.result_dut = 4'b0000;
`ifdef MISR_GOLDEN_PORT_EN
        if_a.golden_signature = GOLD_A;
        if_b.golden_signature = GOLD_B;
`endif
        #3;
        check("rst_misr",   if_a.misr_output, 4'b0000);
        check("rst_busy",   {3'b0, if_a.busy}, 4'd0);
        check("rst_finish", {3'b0, if_a.finish}, 4'd0);
        check("rst_fault",  {3'b0, if_a.fault_detected}, 4'd0);
        #9 rst = 1'b0;
        tick();

        // Signature match / mismatch.
        do_start();
        check("t1_busy", {3'b0, if_a.busy}, 4'd1);
        sample(4'b0010); check("t1_s1", if_a.misr_output, 4'b0010);
        sample(4'b0101); check("t1_s2", if_a.misr_output, 4'b0001);
        sample(4'b1011); check("t1_s3", if_a.misr_output, 4'b1001);
        sample(4'b1111); check("t1_s4", if_a.misr_output, 4'b1110);
        check("t1_model_sig", sig, 4'b1110);
        check("t1_finish_e0", {3'b0, if_a.finish}, 4'd0);
        tick();
        check("t1_finish_e1", {3'b0, if_a.finish}, 4'd1);
        check("t1_fault_a", {3'b0, if_a.fault_detected}, 4'd0);
        check("t1_fault_b", {3'b0, if_b.fault_detected}, 4'd1);
        check("t1_misr_b", if_b.misr_output, 4'b1110);
        tick();
        check("t1_hold", if_a.misr_output, 4'b1110);

        // Restart from DONE, valid gaps, start ignored mid-run.
        do_start();
        check("t2_reload", if_a.misr_output, 4'b0000);
        check("t2_fault_clr", {3'b0, if_b.fault_detected}, 4'd0);
        sample(4'b0010);
        sample(4'b0101);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_gap", if_a.misr_output, 4'b0001);
        end
        sample(4'b1011);
        if_a.start = 1'b1;
        sample(4'b1111);
        if_a.start = 1'b0;
        tick();
        check("t2_finish", {3'b0, if_a.finish}, 4'd1);
        check("t2_sig", if_a.misr_output, 4'b1110);

        // DONE -> IDLE when BIST_mode drops; idle ignores start and din_valid.
        if_a.BIST_mode = 1'b0;
        tick();
        check("t2_idle_finish", {3'b0, if_b.finish}, 4'd0);
        check("t2_idle_fault",  {3'b0, if_b.fault_detected}, 4'd0);
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        check("idle_start_ign", {3'b0, if_a.busy}, 4'd0);
        sample(4'b1010);
        check("idle_dv_ign", if_a.misr_output, 4'b1110);

        // Abort mid-run.
        do_start();
        sample(4'b0010);
        sample(4'b0101);
        if_a.BIST_mode = 1'b0;
        tick();
        check("t3_misr", if_a.misr_output, 4'b0000);
        check("t3_busy", {3'b0, if_a.busy}, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_no_finish", {3'b0, if_a.finish}, 4'd0);
        end

        // Asynchronous reset mid-run, then an all-zero run.
        do_start();
        sample(4'b0010);
        sample(4'b0101);
        sample(4'b1011);
        #1 rst = 1'b1;
        #1;
        check("t4_rst_misr",  if_a.misr_output, 4'b0000);
        check("t4_rst_busy",  {3'b0, if_a.busy}, 4'd0);
        check("t4_rst_fin",   {3'b0, if_a.finish}, 4'd0);
        check("t4_rst_fault", {3'b0, if_a.fault_detected}, 4'd0);
        #1 rst = 1'b0;
        tick();
        do_start();
        for (int i = 0; i < PC; i++) sample(4'b0000);
        tick();
        check("t4_finish",  {3'b0, if_b.finish}, 4'd1);
        check("t4_sig",     if_b.misr_output, 4'b0000);
        check("t4_fault_b", {3'b0, if_b.fault_detected}, 4'd1);
        check("t4_fault_a", {3'b0, if_a.fault_detected}, 4'd1);

`ifdef MISR_GOLDEN_PORT_EN
        // Golden captured at run start; later port changes must not matter.
        if_a.golden_signature = 4'b1110;
        if_b.golden_signature = 4'b0101;
        do_start();
        sample(4'b0010);
        sample(4'b0101);
        if_a.golden_signature = 4'b0000;
        if_b.golden_signature = 4'b0000;
        sample(4'b1011);
        sample(4'b1111);
        tick();
        check("t5_finish",  {3'b0, if_a.finish}, 4'd1);
        check("t5_fault_a", {3'b0, if_a.fault_detected}, 4'd0);
        check("t5_fault_b", {3'b0, if_b.fault_detected}, 4'd1);
`endif

        if_a.BIST_mode = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
